// File: rtl/soh_input_sequencer_pkg.sv
// soh_pkg: shared constants and FSM state type for the SoH input sequencer.
// Fixed-point words are signed Q16.16 throughout.
package soh_pkg;

  localparam int SOH_DATA_W    = 32;
  localparam int SOH_FRAC_BITS = 16;

  localparam logic [SOH_DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [SOH_DATA_W-1:0] SAT_MIN = 32'h8000_0000;
  localparam logic [SOH_DATA_W-1:0] Q_ONE   = 32'h0001_0000;
  localparam logic [SOH_DATA_W-1:0] Q_ZERO  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DONE    = 2'd2
  } soh_state_t;

endpackage

// File: rtl/soh_input_sequencer_if.sv
// soh_input_sequencer_if: raw-feature handshake and result handshake bundle.
// master = feature producer / result consumer, slave = the sequencer.
interface soh_input_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              result_valid;
  logic              result_ready;
  logic [DATA_W-1:0] result_data;

  modport master (
    output s_valid, s_data, result_ready,
    input  s_ready, result_valid, result_data
  );

  modport slave (
    input  s_valid, s_data, result_ready,
    output s_ready, result_valid, result_data
  );
endinterface

// File: rtl/soh_input_sequencer_normalizer.sv
// soh_feature_normalizer: combinational sat(((x - offset) * scale) >>> FRAC_BITS).
// The difference is one bit wider than a word and the product is wide enough
// that neither can wrap; only the final narrowing saturates.
module soh_feature_normalizer
  import soh_pkg::*;
#(
  parameter int DATA_W    = SOH_DATA_W,
  parameter int FRAC_BITS = SOH_FRAC_BITS
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] offset,
  input  logic [DATA_W-1:0] scale,
  output logic [DATA_W-1:0] norm,
  output logic              sat
);

  localparam int PW = 2*DATA_W + 2;

  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   diff_ext;
  logic signed [PW-1:0]   scale_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   shifted;
  logic [PW-DATA_W:0]     top_bits;

  assign diff      = signed'({x[DATA_W-1], x}) - signed'({offset[DATA_W-1], offset});
  assign diff_ext  = PW'(diff);
  assign scale_ext = PW'(signed'(scale));
  assign prod      = diff_ext * scale_ext;
  assign shifted   = prod >>> FRAC_BITS;
  // Everything from the result sign bit upward must be a pure sign extension.
  assign top_bits  = shifted[PW-1:DATA_W-1];

  // Narrow to one word, clamping to the signed range when it does not fit.
  always_comb begin
    sat  = !((&top_bits) || !(|top_bits));
    norm = shifted[DATA_W-1:0];
    if (sat) begin
      norm = shifted[PW-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/soh_input_sequencer.sv
// soh_input_sequencer: normalizes raw features into the predictor input
// vector, holds it for the predictor latency, then offers the SoH result.
// Optional build macro SOH_RESULT_CLAMP_EN clamps the captured SoH to [0.0, 1.0].
//
// state      | meaning
// ST_COLLECT | accepting features, one normalized slice per handshake
// ST_HOLD    | vector stable, waiting NET_LATENCY edges for the predictor
// ST_DONE    | result offered, waiting for the consumer handshake
module soh_input_sequencer
  import soh_pkg::*;
#(
  parameter int NUM_FEATURES = 4,
  parameter int DATA_W       = SOH_DATA_W,
  parameter int FRAC_BITS    = SOH_FRAC_BITS,
  parameter int NET_LATENCY  = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  soh_input_sequencer_if.slave             bus,
  input  logic [NUM_FEATURES*DATA_W-1:0]   offsets,
  input  logic [NUM_FEATURES*DATA_W-1:0]   scales,
  output logic [NUM_FEATURES*DATA_W-1:0]   net_in_data,
  input  logic [DATA_W-1:0]                soh_in,
  output logic                             sat_flag,
  output logic [15:0]                      frame_cnt
);

  localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int CNT_W = (NET_LATENCY > 0) ? $clog2(NET_LATENCY + 2) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  soh_state_t                     state, state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [CNT_W-1:0]               hold_cnt;
  logic [NUM_FEATURES*DATA_W-1:0] net_q;
  logic [DATA_W-1:0]              res_q;
  logic [DATA_W-1:0]              soh_cap;
  logic                           sat_q;
  logic [15:0]                    frame_q;
  logic [DATA_W-1:0]              off_sel, scl_sel, norm;
  logic                           norm_sat;
  logic                           s_ready_c, res_valid_c;
  logic                           accept, res_hs;

  // Pick this feature's offset and scale; feature 0 lives in the top slice.
  always_comb begin
    off_sel = '0;
    scl_sel = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (idx == IDX_W'(i)) begin
        off_sel = offsets[(NUM_FEATURES-1-i)*DATA_W +: DATA_W];
        scl_sel = scales[(NUM_FEATURES-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  soh_feature_normalizer #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_norm (
    .x      (bus.s_data),
    .offset (off_sel),
    .scale  (scl_sel),
    .norm   (norm),
    .sat    (norm_sat)
  );

  // Result capture, optionally clamped to the physical SoH range.
  always_comb begin
    soh_cap = soh_in;
`ifdef SOH_RESULT_CLAMP_EN
    if (soh_in[DATA_W-1]) begin
      soh_cap = Q_ZERO;
    end else if (soh_in > Q_ONE) begin
      soh_cap = Q_ONE;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    s_ready_c   = 1'b0;
    res_valid_c = 1'b0;
    case (state)
      ST_COLLECT: begin
        s_ready_c = 1'b1;
        if (bus.s_valid && (idx == LAST_IDX)) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == CNT_W'(NET_LATENCY)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid_c = 1'b1;
        if (bus.result_ready) begin
          state_nxt = ST_COLLECT;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  assign accept = bus.s_valid && s_ready_c;
  assign res_hs = res_valid_c && bus.result_ready;

  // Feature index, hold timer, vector slices, result and frame bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      hold_cnt <= '0;
      net_q    <= '0;
      res_q    <= '0;
      sat_q    <= 1'b0;
      frame_q  <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < NUM_FEATURES; i++) begin
          if (idx == IDX_W'(i)) begin
            net_q[(NUM_FEATURES-1-i)*DATA_W +: DATA_W] <= norm;
          end
        end
        if (norm_sat) begin
          sat_q <= 1'b1;
        end
        if (idx == LAST_IDX) begin
          idx      <= '0;
          hold_cnt <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == CNT_W'(NET_LATENCY)) begin
          res_q <= soh_cap;
        end
      end
      if (res_hs) begin
        frame_q <= frame_q + 16'd1;
        sat_q   <= 1'b0;
      end
    end
  end

  assign bus.s_ready      = s_ready_c;
  assign bus.result_valid = res_valid_c;
  assign bus.result_data  = res_q;
  assign net_in_data      = net_q;
  assign sat_flag         = sat_q;
  assign frame_cnt        = frame_q;

endmodule

// File: tb/tb_soh_input_sequencer.sv
// Directed bench for soh_input_sequencer: identity path, normalization,
// saturation, result backpressure and reset during the hold phase.
module tb_soh_input_sequencer;

  localparam int NF = 4;
  localparam int DW = 32;

`ifdef SOH_RESULT_CLAMP_EN
  localparam logic [31:0] EXP_HI  = 32'h0001_0000;
  localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_HI  = 32'h0001_2000;
  localparam logic [31:0] EXP_NEG = 32'hFFFF_F000;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NF*DW-1:0]  offsets;
  logic [NF*DW-1:0]  scales;
  logic [NF*DW-1:0]  net_in_data;
  logic [DW-1:0]     soh_in;
  logic              sat_flag;
  logic [15:0]       frame_cnt;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  soh_input_sequencer_if #(.DATA_W(DW)) sif ();

  soh_input_sequencer #(
    .NUM_FEATURES (NF),
    .DATA_W       (DW),
    .FRAC_BITS    (16),
    .NET_LATENCY  (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif),
    .offsets     (offsets),
    .scales      (scales),
    .net_in_data (net_in_data),
    .soh_in      (soh_in),
    .sat_flag    (sat_flag),
    .frame_cnt   (frame_cnt)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one feature; returns 1 ns after the accepting edge.
  task automatic send_feature(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    while (!sif.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
  endtask

  // Count edges until result_valid rises.
  task automatic wait_result(output int edges);
    edges = 0;
    while (!sif.result_valid && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    sif.result_ready = 1'b1;
    @(posedge clk);
    #1;
    sif.result_ready = 1'b0;
  endtask

  initial begin
    sif.s_valid      = 1'b0;
    sif.s_data       = '0;
    sif.result_ready = 1'b0;
    offsets          = '0;
    scales           = {4{32'h0001_0000}};
    soh_in           = 32'h0000_E666;

    #12;
    check_val("rst_s_ready", sif.s_ready, 1'b1);
    check_val("rst_rvalid", sif.result_valid, 1'b0);
    check_val("rst_rdata", sif.result_data, 32'h0);
    check_val("rst_net", net_in_data, 128'h0);
    check_val("rst_sat", sat_flag, 1'b0);
    check_val("rst_fcnt", frame_cnt, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // Frame 1: identity normalization.
    send_feature(32'h0002_0000);
    send_feature(32'h0001_8000);
    send_feature(32'hFFFF_0000);
    check_val("f1_partial_rvalid", sif.result_valid, 1'b0);
    send_feature(32'h0000_0001);
    check_val("f1_hold_s_ready", sif.s_ready, 1'b0);
    check_val("f1_net", net_in_data, {32'h0002_0000, 32'h0001_8000, 32'hFFFF_0000, 32'h0000_0001});
    wait_result(lat);
    check_val("f1_latency", lat, 6);
    check_val("f1_rdata", sif.result_data, 32'h0000_E666);
    check_val("f1_sat", sat_flag, 1'b0);
    take_result();
    check_val("f1_rvalid_clr", sif.result_valid, 1'b0);
    check_val("f1_fcnt", frame_cnt, 16'd1);
    check_val("f1_s_ready", sif.s_ready, 1'b1);

    // Frame 2: offsets/scales, saturation, backpressure.
    offsets = {32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000};
    scales  = {32'h0000_8000, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000};
    soh_in  = 32'h0001_2000;
    send_feature(32'h0005_0000);
    check_val("f2_keep_slices", net_in_data, {32'h0002_0000, 32'h0001_8000, 32'hFFFF_0000, 32'h0000_0001});
    send_feature(32'h0000_0000);
    check_val("f2_sat_before", sat_flag, 1'b0);
    send_feature(32'h7FFF_0000);
    check_val("f2_sat_set", sat_flag, 1'b1);
    send_feature(32'h0003_0000);
    check_val("f2_net", net_in_data, {32'h0002_0000, 32'hFFFE_0000, 32'h7FFF_FFFF, 32'h0003_0000});
    wait_result(lat);
    check_val("f2_latency", lat, 6);
    check_val("f2_rdata", sif.result_data, EXP_HI);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sif.s_valid = 1'b1;
      sif.s_data  = 32'h1234_5678;
      soh_in      = 32'h0000_1111 * (i + 1);
      @(posedge clk);
      #1;
      check_val("bp_rvalid", sif.result_valid, 1'b1);
      check_val("bp_rdata", sif.result_data, EXP_HI);
      check_val("bp_s_ready", sif.s_ready, 1'b0);
    end
    sif.s_valid = 1'b0;
    check_val("bp_net", net_in_data, {32'h0002_0000, 32'hFFFE_0000, 32'h7FFF_FFFF, 32'h0003_0000});
    check_val("bp_fcnt", frame_cnt, 16'd1);
    take_result();
    check_val("f2_fcnt", frame_cnt, 16'd2);
    check_val("f2_sat_clr", sat_flag, 1'b0);

    // Frame 3: ignored pulses not consumed; negative SoH.
    offsets = '0;
    scales  = {4{32'h0001_0000}};
    soh_in  = 32'hFFFF_F000;
    send_feature(32'h0000_0001);
    check_val("f3_first_slice", net_in_data, {32'h0000_0001, 32'hFFFE_0000, 32'h7FFF_FFFF, 32'h0003_0000});
    send_feature(32'h0000_0002);
    send_feature(32'h0000_0003);
    send_feature(32'h0000_0004);
    check_val("f3_net", net_in_data, {32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004});
    wait_result(lat);
    check_val("f3_latency", lat, 6);
    check_val("f3_rdata", sif.result_data, EXP_NEG);
    take_result();
    check_val("f3_fcnt", frame_cnt, 16'd3);

    // Frame 4: reset two edges into the hold phase.
    send_feature(32'h0000_0010);
    send_feature(32'h0000_0020);
    send_feature(32'h0000_0030);
    send_feature(32'h0000_0040);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("mr_net", net_in_data, 128'h0);
    check_val("mr_rvalid", sif.result_valid, 1'b0);
    check_val("mr_s_ready", sif.s_ready, 1'b1);
    check_val("mr_fcnt", frame_cnt, 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // Frame 5: normal completion after reset.
    soh_in = 32'h0000_8000;
    send_feature(32'h0001_0000);
    send_feature(32'h0002_0000);
    send_feature(32'h0003_0000);
    send_feature(32'h0004_0000);
    check_val("f5_net", net_in_data, {32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000});
    wait_result(lat);
    check_val("f5_latency", lat, 6);
    check_val("f5_rdata", sif.result_data, 32'h0000_8000);
    take_result();
    check_val("f5_fcnt", frame_cnt, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
